ram_arbiter: RTL

- Sits between the CPU core and a single-port synchronous SRAM; replaces the dual-port simulation RAM so the core can run on real single-port memory.
- Arbitrates the core's instruction-fetch port (from pc_reg) and data port (from ex) onto one SRAM port, returns read data with fixed latency, and raises a stall toward the core when fetch is not served.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arb_prio.sv | 37 +++
 rtl/ram_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared widths and response state encodings for ram_arbiter
package ram_arbiter_pkg;

  localparam int SRAM_ADDR_W      = 32;
  localparam int SRAM_DATA_W      = 32;
  localparam int MAX_DATA_RUN_DEF = 4;

  typedef logic [1:0] resp_state_t;

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_D    = 2'd1;
  localparam logic [1:0] RESP_F    = 2'd2;

endpackage

// File: rtl/ram_arb_prio.sv
// rtl/ram_arb_prio.sv - data-priority arbiter with fetch starvation counter
module ram_arb_prio
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_req,
  input  logic f_req,
  output logic d_win,
  output logic f_win
);

  localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_RUN);

  logic [CNT_W-1:0] r_run_cnt;
  logic             w_starved;

  assign w_starved = (r_run_cnt == CNT_MAX);

  // Grants are suppressed while reset is asserted so no SRAM access leaks out.
  assign d_win = ~rst & d_req & (~f_req | ~w_starved);
  assign f_win = ~rst & f_req & ~d_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (~f_req | f_win) begin
      r_run_cnt <= '0;
    end else if (d_win && !w_starved) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port SRAM arbiter for core fetch and data ports
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              hold_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic        w_d_win;
  logic        w_f_win;
  resp_state_t r_state;
  resp_state_t w_state_nxt;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] r_f_rdata;

  ram_arb_prio #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .d_req (d_req_i),
    .f_req (f_req_i),
    .d_win (w_d_win),
    .f_win (w_f_win)
  );

  assign d_gnt_o = w_d_win;
  assign f_gnt_o = w_f_win;
  assign hold_o  = ~rst & f_req_i & ~w_f_win;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_d_win) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (w_f_win) begin
      mem_en_o   = 1'b1;
      mem_addr_o = f_addr_i;
    end
  end

  always_comb begin
    w_state_nxt = RESP_IDLE;
    if (w_d_win && !d_we_i) begin
      w_state_nxt = RESP_D;
    end else if (w_f_win) begin
      w_state_nxt = RESP_F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RESP_IDLE;
      r_d_rdata <= '0;
      r_f_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RESP_D) r_d_rdata <= mem_rdata_i;
      if (r_state == RESP_F) r_f_rdata <= mem_rdata_i;
    end
  end

  // SRAM data is presented directly in the response cycle, then held from the register.
  assign d_rvalid_o = (r_state == RESP_D);
  assign f_rvalid_o = (r_state == RESP_F);
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : r_d_rdata;
  assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : r_f_rdata;

endmodule
